// File: rtl/button_bounce_gen.sv
// button_bounce_gen: emulated mechanical pushbutton that bounces before settling at a requested level
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  command present (only looked at in IDLE)
//   req_level  requested settled level of pb_1, sampled at acceptance
//   req_ready  high only in IDLE
//   pb_1       registered bouncy button line
//   busy       inverse of req_ready
//   done       one-cycle completion pulse
//
// Build option: BTN_BOUNCE_RANDOM_EN selects LFSR-driven segment lengths;
// without it every bounce segment is exactly 2 cycles.
module button_bounce_gen #(
    parameter int         BOUNCES    = 4,
    parameter int         W_BITS     = 3,
    parameter int         SETTLE     = 64,
    parameter logic [7:0] SEED       = 8'hA5,
    parameter logic       INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic pb_1,
    output logic busy,
    output logic done
);
    localparam int         MAXC = ((1 << W_BITS) > SETTLE) ? (1 << W_BITS) : SETTLE;
    localparam int         CW   = $clog2(MAXC + 1);
    localparam logic [3:0] NB   = 4'(BOUNCES);

    typedef enum logic [1:0] {S_IDLE, S_MAKE, S_BREAK, S_SETTLE} state_t;

    state_t        state_q, state_d;
    logic          pb_q, pb_d, tgt_q, tgt_d, done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d, seg_len;
    logic [3:0]    pair_q, pair_d;

`ifdef BTN_BOUNCE_RANDOM_EN
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    logic [7:0] lfsr_q, lfsr_d;
    logic       load;
    // every entry into MAKE or BREAK consumes one segment length
    assign load    = (state_d != state_q) && (state_d == S_MAKE || state_d == S_BREAK);
    assign lfsr_d  = load ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    assign seg_len = {{(CW - W_BITS){1'b0}}, lfsr_q[W_BITS-1:0]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= SEED_EFF;
        else        lfsr_q <= lfsr_d;
`else
    assign seg_len = CW'(1);
`endif

    // cnt_q holds remaining cycles minus one, so a segment of L cycles loads L-1
    always_comb begin
        state_d = state_q;
        pb_d    = pb_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        case (state_q)
            S_IDLE:
                if (req_valid) begin
                    tgt_d = req_level;
                    if (req_level == pb_q) done_d = 1'b1;
                    else begin
                        pb_d    = req_level;
                        pair_d  = 4'd0;
                        state_d = (NB == 4'd0) ? S_SETTLE : S_MAKE;
                        cnt_d   = (NB == 4'd0) ? CW'(SETTLE - 1) : seg_len;
                    end
                end
            S_MAKE:
                if (cnt_q == '0) begin
                    pb_d    = !tgt_q;
                    cnt_d   = seg_len;
                    state_d = S_BREAK;
                end else cnt_d = cnt_q - 1'b1;
            S_BREAK:
                if (cnt_q == '0) begin
                    pb_d    = tgt_q;
                    pair_d  = pair_q + 4'd1;
                    state_d = (pair_d < NB) ? S_MAKE : S_SETTLE;
                    cnt_d   = (pair_d < NB) ? seg_len : CW'(SETTLE - 1);
                end else cnt_d = cnt_q - 1'b1;
            default:
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else cnt_d = cnt_q - 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            pb_q    <= INIT_LEVEL;
            tgt_q   <= INIT_LEVEL;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            pb_q    <= pb_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
        end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = !req_ready;
    assign pb_1      = pb_q;
    assign done      = done_q;
endmodule

// File: doc/button_bounce_gen.md
# button_bounce_gen

Synthesizable mechanical-button emulator: takes clean press/release commands over a valid/ready handshake and drives a single-bit pushbutton line with a burst of contact bounce before settling at the requested level. Its output drives the `pb_1` input of the team's button debouncers, for on-board self-test and for RTL benches that exercise debouncing without hand-written glitch sequences. Bounce segment lengths come from an internal LFSR, so the pattern is reproducible from a seed.

## Interface
Parameters:
- `BOUNCES`, 4: number of bounce pairs per level change; 0..15 legal.
- `W_BITS`, 3: random segment length field width; segment length is 1..2^W_BITS cycles.
- `SETTLE`, 64: cycles the final level is held before `done`; 1..65535.
- `SEED`, 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.
- `INIT_LEVEL`, 1'b0: `pb_1` level after reset (released).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_level`  in  1  requested settled level of `pb_1`.
- `req_ready`  out  1  high only in IDLE.
- `pb_1`  out  1  emulated bouncy button line, registered.
- `busy`  out  1  equals `!req_ready`.
- `done`  out  1  one-cycle pulse when the command completes.

## Operation
- Reset (async assert, sync release): state IDLE, `pb_1`=INIT_LEVEL, `done`=0, `req_ready`=1, `busy`=0, LFSR=SEED, counters 0.
- States: IDLE, MAKE, BREAK, SETTLE.
- IDLE: accept on `req_valid && req_ready` at edge E0; latch target T=`req_level`.
  - T == `pb_1`: no output activity; `done`=1 for the cycle after E0; stay IDLE.
  - T != `pb_1`, BOUNCES>0: at E0 `pb_1`<=T, load segment length L, enter MAKE.
  - T != `pb_1`, BOUNCES==0: at E0 `pb_1`<=T, enter SETTLE.
- MAKE: hold T for L cycles, then `pb_1`<=!T, load new L, enter BREAK.
- BREAK: hold !T for L cycles. Then increment the pair count and `pb_1`<=T. If the count is below BOUNCES, load L and enter MAKE; otherwise enter SETTLE.
- SETTLE: hold T for SETTLE cycles, then `done`=1 for one cycle and return to IDLE at the same edge.
- Segment length: L = LFSR[W_BITS-1:0] + 1. The LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, and advances once per load. Counters are sized for max(2^W_BITS, SETTLE) without wrap.
- `req_valid` is ignored outside IDLE. `req_level` is sampled only at acceptance.
- Reset mid-burst aborts immediately to reset values. No `done` is issued for the aborted command.

## Timing
- `pb_1` changes only at clock edges. Its first change is at the accepting edge E0.
- A bounce pair lasts L_make + L_break cycles. Total active time = sum of pair lengths + SETTLE.
- `done` is high for exactly one cycle. `req_ready` is high in that same cycle, so back-to-back commands are accepted with no gap cycle.
- The same-level no-op completes in 1 cycle: `done` follows E0 and `req_ready` never drops.
- Minimum `pb_1` pulse width is 1 cycle, at W_BITS segment value 0.

## Configuration
- `BTN_BOUNCE_RANDOM_EN` defined: segment lengths come from the LFSR as above.
- Not defined: the LFSR is not built, and every MAKE and BREAK segment lasts exactly 2 cycles. `SEED` and `W_BITS` are unused. Patterns are fully deterministic for golden-waveform checks.

## Test plan
- Macro off, defaults, request level 1 at E0: `pb_1` = 1,1,0,0 repeated 4 times (E0..E0+15), then 1 from E0+16. `done` is high only in the cycle after edge E0+80, and `busy` is high E0..E0+80.
- Macro off, request level 1 then level 1 again: the second command produces `done` the cycle after acceptance, with no `pb_1` change and `req_ready` held high.
- Macro off, BOUNCES=0, SETTLE=5, request 1: `pb_1` rises at E0 with no glitches, and `done` follows edge E0+5.
- Macro on, SEED=8'hA5: every segment length is in 1..8. The sequence matches a reference LFSR model and is identical across two runs. Holding `req_valid` high mid-burst does not affect the output.
- Assert `rst_n`=0 during BREAK: `pb_1` immediately returns to 0, `busy`=0, and there is no `done` pulse. A fresh request after release starts from LFSR=SEED.
- Drive a debouncer from `pb_1` with press, then release: the debouncer output shows a single rising transition and a single falling transition.
